overflow_underflow_rectifier: RTL and testbench

// - Saturating narrower for signed two's-complement data: clamps a wide accumulator value into a narrow signed range.
// - Sits after MAC/accumulate stages of the neural-network datapath, before results are stored or fed to the next layer.
// - Registered output; no handshake, processes one sample per clock.

---
 rtl/overflow_underflow_rectifier.sv | 72 +++++++
 tb/tb_overflow_underflow_rectifier.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/overflow_underflow_rectifier.sv
// Saturating narrower: clamps a signed wide accumulator value into a narrow signed range, registered.
// Optional macro OVERFLOW_UNDERFLOW_RECTIFIER_STICKY_FLAGS_EN makes the flags sticky until reset.
module overflow_underflow_rectifier #(
    parameter int unsigned UNRECTIFIED_DATA_WIDTH = 32,
    parameter int unsigned RECTIFIED_DATA_WIDTH   = 16
) (
    input  logic                              clk_in,
    input  logic                              rst_n_in,
    input  logic [UNRECTIFIED_DATA_WIDTH-1:0] unrectified_data_in,
    output logic [RECTIFIED_DATA_WIDTH-1:0]   rectified_data_out,
    output logic                              overflow_out,
    output logic                              underflow_out
);

    localparam int unsigned U = UNRECTIFIED_DATA_WIDTH;
    localparam int unsigned R = RECTIFIED_DATA_WIDTH;
    localparam int unsigned H = U - R + 1;

    localparam logic [R-1:0] MaxVal = {1'b0, {(R-1){1'b1}}};
    localparam logic [R-1:0] MinVal = {1'b1, {(R-1){1'b0}}};

    logic [H-1:0] w_upper;
    logic         w_in_range;
    logic         w_ovf;
    logic         w_unf;
    logic [R-1:0] w_data;

    logic [R-1:0] r_data;
    logic         r_ovf;
    logic         r_unf;

    // Bits [U-1:R-1] all equal means the value fits; with U == R this is a single bit, always in range.
    assign w_upper    = unrectified_data_in[U-1:R-1];
    assign w_in_range = (w_upper == {H{1'b0}}) || (w_upper == {H{1'b1}});

    always_comb begin
        w_ovf  = 1'b0;
        w_unf  = 1'b0;
        w_data = unrectified_data_in[R-1:0];
        if (!w_in_range) begin
            if (unrectified_data_in[U-1]) begin
                w_unf  = 1'b1;
                w_data = MinVal;
            end else begin
                w_ovf  = 1'b1;
                w_data = MaxVal;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_data <= '0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
        end else begin
            r_data <= w_data;
`ifdef OVERFLOW_UNDERFLOW_RECTIFIER_STICKY_FLAGS_EN
            r_ovf  <= r_ovf | w_ovf;
            r_unf  <= r_unf | w_unf;
`else
            r_ovf  <= w_ovf;
            r_unf  <= w_unf;
`endif
        end
    end

    assign rectified_data_out = r_data;
    assign overflow_out       = r_ovf;
    assign underflow_out      = r_unf;

endmodule

// File: tb/tb_overflow_underflow_rectifier.sv
// Directed, table-driven bench for overflow_underflow_rectifier (U=32, R=16).
// Tracks sticky flag expectations when OVERFLOW_UNDERFLOW_RECTIFIER_STICKY_FLAGS_EN is defined.
module tb_overflow_underflow_rectifier;

    logic        clk;
    logic        rst_n;
    logic [31:0] din;
    logic [15:0] dout;
    logic        ovf;
    logic        unf;

    int n_total = 0;
    int n_pass  = 0;
    bit sticky_mode;
    logic sticky_ovf;
    logic sticky_unf;

    typedef struct {
        logic [31:0] din;
        logic [15:0] dout;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t vecs[12];

    overflow_underflow_rectifier #(
        .UNRECTIFIED_DATA_WIDTH(32),
        .RECTIFIED_DATA_WIDTH  (16)
    ) u_dut (
        .clk_in             (clk),
        .rst_n_in           (rst_n),
        .unrectified_data_in(din),
        .rectified_data_out (dout),
        .overflow_out       (ovf),
        .underflow_out      (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] exp_d, input logic exp_o,
                         input logic exp_u);
        n_total++;
        if (dout === exp_d && ovf === exp_o && unf === exp_u) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got data=%h ovf=%b unf=%b, expected data=%h ovf=%b unf=%b",
                     name, dout, ovf, unf, exp_d, exp_o, exp_u);
        end
    endtask

    // Drive between edges, then sample 1ns after the capturing edge.
    task automatic apply(input logic [31:0] value);
        @(negedge clk);
        din = value;
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef OVERFLOW_UNDERFLOW_RECTIFIER_STICKY_FLAGS_EN
        sticky_mode = 1'b1;
`else
        sticky_mode = 1'b0;
`endif
        sticky_ovf = 1'b0;
        sticky_unf = 1'b0;

        vecs[0]  = '{32'h7FFF_FFFF, 16'h7FFF, 1'b1, 1'b0};
        vecs[1]  = '{32'h8000_0000, 16'h8000, 1'b0, 1'b1};
        vecs[2]  = '{32'h0000_8000, 16'h7FFF, 1'b1, 1'b0};  // 32768
        vecs[3]  = '{32'hFFFF_7FFF, 16'h8000, 1'b0, 1'b1};  // -32769
        vecs[4]  = '{32'h0000_7FFF, 16'h7FFF, 1'b0, 1'b0};  // 32767
        vecs[5]  = '{32'hFFFF_8000, 16'h8000, 1'b0, 1'b0};  // -32768
        vecs[6]  = '{32'h0000_3039, 16'h3039, 1'b0, 1'b0};  // 12345
        vecs[7]  = '{32'hFFFF_CFC7, 16'hCFC7, 1'b0, 1'b0};  // -12345
        vecs[8]  = '{32'h0000_0000, 16'h0000, 1'b0, 1'b0};
        vecs[9]  = '{32'hFFFF_FFFF, 16'hFFFF, 1'b0, 1'b0};
        vecs[10] = '{32'h0001_0000, 16'h7FFF, 1'b1, 1'b0};
        vecs[11] = '{32'hFFFF_0000, 16'h8000, 1'b0, 1'b1};

        rst_n = 1'b0;
        din   = 32'h7FFF_FFFF;
        #2;
        check("reset_async", 16'h0000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("reset_held_over_edge", 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i].din);
            sticky_ovf = sticky_mode ? (sticky_ovf | vecs[i].ovf) : vecs[i].ovf;
            sticky_unf = sticky_mode ? (sticky_unf | vecs[i].unf) : vecs[i].unf;
            check($sformatf("vec%0d_%h", i, vecs[i].din), vecs[i].dout, sticky_ovf, sticky_unf);
        end

        // Latency: new input must not show before the next rising edge.
        @(negedge clk);
        din = 32'h0000_3039;
        #1;
        check("latency_before_edge", 16'h8000, sticky_ovf, sticky_unf);
        @(posedge clk);
        #1;
        sticky_ovf = sticky_mode ? sticky_ovf : 1'b0;
        sticky_unf = sticky_mode ? sticky_unf : 1'b0;
        check("latency_after_edge", 16'h3039, sticky_ovf, sticky_unf);

        // Async reset mid-cycle clears everything immediately.
        #3;
        rst_n = 1'b0;
        #1;
        check("reset_mid_stream", 16'h0000, 1'b0, 1'b0);
        din = 32'h7FFF_FFFF;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_edge_after_release", 16'h7FFF, 1'b1, 1'b0);

        // Overflow followed by an in-range value: flag persists only in sticky mode.
        apply(32'h0000_0064);
        check("after_ovf_value_100", 16'h0064, sticky_mode, 1'b0);
        apply(32'hFFFF_0000);
        check("underflow_after_ovf", 16'h8000, sticky_mode, 1'b1);
        apply(32'h0000_0001);
        check("both_flags_hold", 16'h0001, sticky_mode, sticky_mode);

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_clears_flags", 16'h0000, 1'b0, 1'b0);
        rst_n = 1'b1;
        apply(32'h0000_0064);
        check("post_reset_100", 16'h0064, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
